duck_palette_ctrl: RTL and testbench

//  Owns the 16-entry 12-bit RGB palette used by the duck sprite pipeline: pixel-side lookup plus game-side updates.

---
 rtl/duck_palette_pkg.sv | 38 +++
 rtl/duck_palette_ctrl_if.sv | 29 ++
 rtl/duck_palette_bank.sv | 34 +++
 rtl/duck_palette_ctrl.sv | 174 +++++++++++++++++
 tb/tb_duck_palette_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/duck_palette_pkg.sv
// Shared types and constants for the duck sprite palette controller.
// Optional hit-flash feature is enabled with `define DUCK_PAL_FLASH_EN.
package duck_palette_pkg;

    localparam int unsigned NUM_ENTRIES  = 16;
    localparam int unsigned COLOR_W      = 12;
    localparam int unsigned IDX_W        = $clog2(NUM_ENTRIES);
    localparam int unsigned FLASH_FRAMES = 8;
    localparam int unsigned FLASH_CNT_W  = $clog2(FLASH_FRAMES + 1);

    typedef logic [COLOR_W-1:0] rgb12_t;
    typedef logic [IDX_W-1:0]   pal_idx_t;

    typedef enum logic [1:0] {
        Idle,
        Pending,
        Copy
    } pal_state_e;

    typedef rgb12_t [NUM_ENTRIES-1:0] palette_t;

    localparam pal_idx_t TRANSPARENT_IDX = '0;
    localparam rgb12_t   FLASH_RGB       = 12'hFFF;
    localparam pal_idx_t LAST_IDX        = pal_idx_t'(NUM_ENTRIES - 1);

    // Listed from entry 15 down to entry 0.
    localparam palette_t DEFAULT_PALETTE = {
        {9{12'hAEA}},
        12'h050, 12'h050, 12'hF76, 12'h000, 12'hFFF, 12'hA01,
        12'hAEA
    };

    // Reset colour of one palette entry.
    function automatic rgb12_t default_color(input pal_idx_t idx);
        return DEFAULT_PALETTE[idx];
    endfunction

endpackage

// File: rtl/duck_palette_ctrl_if.sv
// Bundle of pixel-lookup, game-write and commit signals of the palette controller.
// master = game/pixel side driving requests, slave = palette controller.
interface duck_palette_ctrl_if;
    import duck_palette_pkg::*;

    pal_idx_t pix_index;
    rgb12_t   pix_rgb;
    logic     pix_transp;
    logic     vblank;
    logic     wr_valid;
    logic     wr_ready;
    pal_idx_t wr_index;
    rgb12_t   wr_color;
    logic     commit_req;
    logic     busy;
    logic     commit_done;
    logic     flash_trig;

    modport master (
        output pix_index, vblank, wr_valid, wr_index, wr_color, commit_req, flash_trig,
        input  pix_rgb, pix_transp, wr_ready, busy, commit_done
    );

    modport slave (
        input  pix_index, vblank, wr_valid, wr_index, wr_color, commit_req, flash_trig,
        output pix_rgb, pix_transp, wr_ready, busy, commit_done
    );

endinterface

// File: rtl/duck_palette_bank.sv
// One palette bank: register array with one write port and two asynchronous read ports.
// Reset loads the default palette so both banks always start identical.
module duck_palette_bank
    import duck_palette_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_we,
    input  pal_idx_t i_waddr,
    input  rgb12_t   i_wdata,
    input  pal_idx_t i_raddr_a,
    output rgb12_t   o_rdata_a,
    input  pal_idx_t i_raddr_b,
    output rgb12_t   o_rdata_b
);

    rgb12_t r_mem [NUM_ENTRIES];

    // Storage: defaults on reset, single write per cycle; out-of-range writes are dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mem[i] <= default_color(pal_idx_t'(i));
            end
        end else if (i_we && (32'(i_waddr) < NUM_ENTRIES)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-write contents, giving read-before-write on a same-cycle hit.
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/duck_palette_ctrl.sv
// Duck sprite palette controller: registered pixel lookup from the active bank, game writes
// into a shadow bank, and a commit that copies shadow->active one entry per cycle starting at
// the next vblank rising edge so colours never change mid-frame.
// Optional hit-flash (`define DUCK_PAL_FLASH_EN): non-transparent pixels go white for
// FLASH_FRAMES frames after flash_trig.
module duck_palette_ctrl
    import duck_palette_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    duck_palette_ctrl_if.slave  bus
);

    pal_state_e r_state;
    pal_state_e w_state_d;
    pal_idx_t   r_ptr;
    pal_idx_t   w_ptr_d;
    logic       r_commit_pend;
    logic       w_commit_pend_d;
    logic       r_commit_done;
    logic       w_commit_done_d;
    logic       r_vblank_q;
    logic       w_vb_rise;
    logic       w_copy_we;
    logic       w_wr_fire;
    logic       w_wr_ready;
    logic       w_flash_on;
    rgb12_t     r_pix_rgb;
    logic       r_pix_transp;
    rgb12_t     w_pix_rgb_d;
    rgb12_t     w_shadow_rd;
    rgb12_t     w_active_rd;
    rgb12_t     w_unused_shadow_b;
    rgb12_t     w_unused_active_b;

    assign w_vb_rise  = bus.vblank & ~r_vblank_q;
    assign w_wr_ready = (r_state != Copy);
    assign w_wr_fire  = bus.wr_valid & w_wr_ready;

    duck_palette_bank u_shadow (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_wr_fire),
        .i_waddr   (bus.wr_index),
        .i_wdata   (bus.wr_color),
        .i_raddr_a (r_ptr),
        .o_rdata_a (w_shadow_rd),
        .i_raddr_b (bus.wr_index),
        .o_rdata_b (w_unused_shadow_b)
    );

    duck_palette_bank u_active (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_copy_we),
        .i_waddr   (r_ptr),
        .i_wdata   (w_shadow_rd),
        .i_raddr_a (bus.pix_index),
        .o_rdata_a (w_active_rd),
        .i_raddr_b (r_ptr),
        .o_rdata_b (w_unused_active_b)
    );

    // vblank delay for rising-edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vblank_q <= 1'b0;
        end else begin
            r_vblank_q <= bus.vblank;
        end
    end

    // Commit FSM state, copy pointer, queued-commit flag and done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= Idle;
            r_ptr         <= '0;
            r_commit_pend <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_ptr         <= w_ptr_d;
            r_commit_pend <= w_commit_pend_d;
            r_commit_done <= w_commit_done_d;
        end
    end

    // Next-state logic: wait for a vblank edge, then copy one entry per cycle.
    always_comb begin
        w_state_d       = r_state;
        w_ptr_d         = r_ptr;
        w_commit_pend_d = r_commit_pend;
        w_commit_done_d = 1'b0;
        w_copy_we       = 1'b0;
        unique case (r_state)
            Idle: begin
                // A vb_rise in the same cycle is ignored; the commit waits for the next edge.
                if (bus.commit_req) begin
                    w_state_d = Pending;
                end
            end
            Pending: begin
                if (w_vb_rise) begin
                    w_state_d = Copy;
                    w_ptr_d   = '0;
                end
            end
            Copy: begin
                w_copy_we = 1'b1;
                if (bus.commit_req) begin
                    w_commit_pend_d = 1'b1;
                end
                if (r_ptr == LAST_IDX) begin
                    w_commit_done_d = 1'b1;
                    w_commit_pend_d = 1'b0;
                    w_state_d       = (r_commit_pend || bus.commit_req) ? Pending : Idle;
                end else begin
                    w_ptr_d = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_d = Idle;
            end
        endcase
    end

`ifdef DUCK_PAL_FLASH_EN
    logic [FLASH_CNT_W-1:0] r_flash_cnt;

    // Hit-flash frame counter: trigger (re)loads, each vblank edge counts down to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flash_cnt <= '0;
        end else if (bus.flash_trig) begin
            r_flash_cnt <= FLASH_CNT_W'(FLASH_FRAMES);
        end else if (w_vb_rise && (r_flash_cnt != '0)) begin
            r_flash_cnt <= r_flash_cnt - 1'b1;
        end
    end

    assign w_flash_on = (r_flash_cnt != '0);
`else
    logic w_unused_flash_trig;

    assign w_unused_flash_trig = bus.flash_trig;
    assign w_flash_on          = 1'b0;
`endif

    // Flash overrides colour of opaque pixels only; transparency flag is never affected.
    always_comb begin
        w_pix_rgb_d = w_active_rd;
        if (w_flash_on && (bus.pix_index != TRANSPARENT_IDX)) begin
            w_pix_rgb_d = FLASH_RGB;
        end
    end

    // Registered pixel lookup, one cycle after pix_index, independent of commit state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_rgb    <= '0;
            r_pix_transp <= 1'b0;
        end else begin
            r_pix_rgb    <= w_pix_rgb_d;
            r_pix_transp <= (bus.pix_index == TRANSPARENT_IDX);
        end
    end

    assign bus.pix_rgb     = r_pix_rgb;
    assign bus.pix_transp  = r_pix_transp;
    assign bus.wr_ready    = w_wr_ready;
    assign bus.busy        = (r_state != Idle);
    assign bus.commit_done = r_commit_done;

endmodule

// File: tb/tb_duck_palette_ctrl.sv
// Self-checking bench for duck_palette_ctrl with a palette-level reference model.
module tb_duck_palette_ctrl;
    import duck_palette_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    duck_palette_ctrl_if bus ();

    duck_palette_ctrl u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    rgb12_t shadow_m [16];
    rgb12_t active_m [16];
    int     flash_left = 0;
    int     flash_frames_m;

    function automatic rgb12_t def_color(input int i);
        case (i)
            0:       return 12'hAEA;
            1:       return 12'hA01;
            2:       return 12'hFFF;
            3:       return 12'h000;
            4:       return 12'hF76;
            5, 6:    return 12'h050;
            default: return 12'hAEA;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            shadow_m[i] = def_color(i);
            active_m[i] = def_color(i);
        end
        flash_left = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup_chk(input int idx, input string tag);
        rgb12_t exp;
        bus.pix_index = pal_idx_t'(idx);
        tick();
        exp = (flash_left != 0 && idx != 0) ? 12'hFFF : active_m[idx];
        chk($sformatf("%s_rgb%0d", tag, idx), 32'(bus.pix_rgb), 32'(exp));
        chk($sformatf("%s_transp%0d", tag, idx), 32'(bus.pix_transp), 32'(idx == 0));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) lookup_chk(i, tag);
    endtask

    task automatic write_shadow(input int idx, input rgb12_t c);
        chk("wr_ready_open", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_index = pal_idx_t'(idx);
        bus.wr_color = c;
        tick();
        bus.wr_valid = 1'b0;
        shadow_m[idx] = c;
    endtask

    task automatic pulse_commit();
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
    endtask

    task automatic vb_rise_edge();
        bus.vblank = 1'b0;
        tick();
        bus.vblank = 1'b1;
        tick();
    endtask

    // Counts copy cycles (wr_ready low), bounded; active bank takes the shadow snapshot.
    task automatic wait_copy(input int exp_n, input string tag);
        int n = 0;
        while (bus.wr_ready === 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_copy_len"}, 32'(n), 32'(exp_n));
        chk({tag, "_done_pulse"}, 32'(bus.commit_done), 32'd1);
        for (int i = 0; i < 16; i++) active_m[i] = shadow_m[i];
        tick();
        chk({tag, "_done_clear"}, 32'(bus.commit_done), 32'd0);
    endtask

    initial begin
        rgb12_t c9;
`ifdef DUCK_PAL_FLASH_EN
        flash_frames_m = 8;
`else
        flash_frames_m = 0;
`endif
        bus.pix_index  = '0;
        bus.vblank     = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_index   = '0;
        bus.wr_color   = '0;
        bus.commit_req = 1'b0;
        bus.flash_trig = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        // Reset state
        chk("rst_rgb", 32'(bus.pix_rgb), 32'h000);
        chk("rst_transp", 32'(bus.pix_transp), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.commit_done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        sweep("dflt");

        // Basic commit of idx3 plus random shadow writes
        write_shadow(3, 12'h123);
        for (int k = 0; k < 6; k++) begin
            write_shadow(int'($urandom_range(4, 15)), rgb12_t'($urandom));
        end
        lookup_chk(3, "pre_commit");
        pulse_commit();
        chk("pend_busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        lookup_chk(3, "pend_old");
        chk("pend_ready", 32'(bus.wr_ready), 32'd1);
        vb_rise_edge();
        chk("copy_busy", 32'(bus.busy), 32'd1);
        wait_copy(16, "c1");
        chk("c1_idle", 32'(bus.busy), 32'd0);
        lookup_chk(3, "post_c1");
        sweep("c1");

        // Commit while vblank already high, and commit coinciding with vb_rise
        bus.vblank = 1'b0;
        tick();
        bus.vblank = 1'b1;
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        write_shadow(5, rgb12_t'($urandom));
        for (int k = 0; k < 5; k++) tick();
        chk("vbhigh_busy", 32'(bus.busy), 32'd1);
        chk("vbhigh_nocopy", 32'(bus.wr_ready), 32'd1);
        vb_rise_edge();
        wait_copy(16, "c2");
        sweep("c2");

        // Write held during COPY and a second commit queued from COPY
        write_shadow(7, rgb12_t'($urandom));
        pulse_commit();
        vb_rise_edge();
        c9 = rgb12_t'($urandom);
        bus.wr_valid = 1'b1;
        bus.wr_index = 4'd9;
        bus.wr_color = c9;
        chk("copy_ready_low", 32'(bus.wr_ready), 32'd0);
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        wait_copy(15, "c3");
        bus.wr_valid = 1'b0;
        shadow_m[9] = c9;
        chk("c3_requeued", 32'(bus.busy), 32'd1);
        chk("c3_ready", 32'(bus.wr_ready), 32'd1);
        lookup_chk(9, "c3_old9");
        vb_rise_edge();
        wait_copy(16, "c4");
        chk("c4_idle", 32'(bus.busy), 32'd0);
        lookup_chk(9, "c4_new9");
        lookup_chk(7, "c4_new7");

        // Reset in the middle of a copy
        write_shadow(3, 12'h456);
        pulse_commit();
        vb_rise_edge();
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_rgb", 32'(bus.pix_rgb), 32'h000);
        chk("mid_rst_transp", 32'(bus.pix_transp), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
        chk("mid_rst_done", 32'(bus.commit_done), 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        lookup_chk(3, "after_rst");
        vb_rise_edge();
        chk("after_rst_idle", 32'(bus.busy), 32'd0);
        pulse_commit();
        vb_rise_edge();
        wait_copy(16, "c5");
        lookup_chk(3, "c5_shadow_dflt");

        // Hit-flash over several frames
        bus.flash_trig = 1'b1;
        tick();
        bus.flash_trig = 1'b0;
        flash_left = flash_frames_m;
        for (int f = 0; f < 10; f++) begin
            lookup_chk(1, $sformatf("flash_f%0d", f));
            lookup_chk(0, $sformatf("flash_f%0d", f));
            vb_rise_edge();
            if (flash_left > 0) flash_left--;
        end
        lookup_chk(1, "flash_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
